// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed common-anode 7-segment scan bus into per-position hex values.
// Each {cs, sm_db} pattern must be stable for STABLE_CYC samples before it is accepted.
module seg_scan_decoder #(
  parameter int DIGITS     = 6,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     cs,
  input  logic [6:0]            sm_db,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  seg_err,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

  localparam logic [3:0]        RUN_MAX = 4'(STABLE_CYC);
  localparam logic [DIGITS-1:0] ONE     = DIGITS'(1);

  logic [DIGITS-1:0] cs_q;
  logic [6:0]        sm_q;
  logic [3:0]        run_q, run_d;
  state_t            state_q;
  logic [3:0]        slot_q [DIGITS];
  logic [DIGITS-1:0] valid_q, seen_q;
  logic              frame_q, seg_err_q, bus_err_q;

  // {legal value, blank, value}; neither flag set means illegal pattern
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   return {2'b10, 4'h0};
      7'h79:   return {2'b10, 4'h1};
      7'h24:   return {2'b10, 4'h2};
      7'h30:   return {2'b10, 4'h3};
      7'h19:   return {2'b10, 4'h4};
      7'h12:   return {2'b10, 4'h5};
      7'h02:   return {2'b10, 4'h6};
      7'h78:   return {2'b10, 4'h7};
      7'h00:   return {2'b10, 4'h8};
      7'h10:   return {2'b10, 4'h9};
      7'h08:   return {2'b10, 4'hA};
      7'h03:   return {2'b10, 4'hB};
      7'h46:   return {2'b10, 4'hC};
      7'h21:   return {2'b10, 4'hD};
      7'h06:   return {2'b10, 4'hE};
      7'h0E:   return {2'b10, 4'hF};
      7'h7F:   return {2'b01, 4'h0};
      default: return 6'b00_0000;
    endcase
  endfunction

  logic [5:0]        dec;
  logic [DIGITS-1:0] sel;
  logic              sel_one, sel_all, cs_idle, changed, illegal, accept;
  logic [DIGITS-1:0] wr_mask, seen_d;
  logic              frame_d, seg_err_d, bus_err_d;

  always_comb begin
    run_d = 4'd1;
    if ({cs, sm_db} == {cs_q, sm_q}) begin
      run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q  <= '1;
      sm_q  <= '1;
      run_q <= 4'd0;
    end else begin
      cs_q  <= cs;
      sm_q  <= sm_db;
      run_q <= run_d;
    end
  end

  // A reload to 1 marks that the newest sample differs from the one before it
  always_comb begin
    dec       = seg_decode(sm_q);
    sel       = ~cs_q;
    sel_all   = (cs_q == '0);
    sel_one   = (sel != '0) && ((sel & (sel - ONE)) == '0);
    cs_idle   = &cs_q;
    changed   = (run_q == 4'd1);
    illegal   = ~(dec[5] | dec[4]);
    accept    = (state_q == ARMED) && !cs_idle && (run_q == RUN_MAX);
    wr_mask   = '0;
    seg_err_d = 1'b0;
    bus_err_d = 1'b0;
    if (accept) begin
      if (sel_all || sel_one) begin
        if (illegal) seg_err_d = 1'b1;
        else         wr_mask   = sel_all ? '1 : sel;
      end else begin
        bus_err_d = 1'b1;
      end
    end
    seen_d  = seen_q | wr_mask;
    frame_d = (wr_mask != '0) && (seen_d == '1);
    if (frame_d) seen_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      seg_err_q <= 1'b0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) slot_q[i] <= 4'h0;
    end else begin
      frame_q   <= frame_d;
      seg_err_q <= seg_err_d;
      bus_err_q <= bus_err_d;
      seen_q    <= seen_d;
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_mask[i]) begin
          slot_q[i]  <= dec[3:0];
          valid_q[i] <= dec[5];
        end
      end
      case (state_q)
        IDLE:    if (!cs_idle) state_q <= ARMED;
        ARMED: begin
          if (cs_idle)                 state_q <= IDLE;
          else if (run_q == RUN_MAX)   state_q <= HELD;
        end
        HELD:    if (changed) state_q <= cs_idle ? IDLE : ARMED;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
    assign digits[4*gi +: 4] = slot_q[gi];
  end

  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign seg_err     = seg_err_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: each driven step queues its expected
// slot state and pulse counts, which are popped and compared once the dwell ends.
module tb_seg_scan_decoder;

  localparam int DIGITS = 6;
  localparam int S      = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIGITS-1:0]    cs;
  logic [6:0]           sm_db;
  logic [4*DIGITS-1:0]  digits;
  logic [DIGITS-1:0]    digit_valid;
  logic                 frame_done, seg_err, bus_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .sm_db       (sm_db),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .seg_err     (seg_err),
    .bus_err     (bus_err)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int fd_tot  = 0;
  int se_tot  = 0;
  int be_tot  = 0;

  typedef struct {
    string       tag;
    logic [23:0] dig;
    logic [5:0]  val;
    int          fd, se, be;
    int          fd0, se0, be0;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_tot++;
    if (seg_err === 1'b1)    se_tot++;
    if (bus_err === 1'b1)    be_tot++;
  end

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    $display("step %-14s digits=%h valid=%h fd=%0d se=%0d be=%0d",
             e.tag, digits, digit_valid, fd_tot - e.fd0, se_tot - e.se0, be_tot - e.be0);
    check_eq({e.tag, "_digits"}, 32'(digits), 32'(e.dig));
    check_eq({e.tag, "_valid"},  32'(digit_valid), 32'(e.val));
    check_eq({e.tag, "_fd"},     32'(fd_tot - e.fd0), 32'(e.fd));
    check_eq({e.tag, "_se"},     32'(se_tot - e.se0), 32'(e.se));
    check_eq({e.tag, "_be"},     32'(be_tot - e.be0), 32'(e.be));
  endtask

  // Called at a negedge: drives the pattern, holds it for n edges, then checks.
  task automatic drive(input string tag, input logic [5:0] c, input logic [6:0] s, input int n,
                       input logic [23:0] ed, input logic [5:0] ev,
                       input int efd, input int ese, input int ebe);
    exp_t e;
    e.tag = tag; e.dig = ed; e.val = ev;
    e.fd = efd; e.se = ese; e.be = ebe;
    e.fd0 = fd_tot; e.se0 = se_tot; e.be0 = be_tot;
    sb.push_back(e);
    cs    = c;
    sm_db = s;
    repeat (n) @(negedge clk);
    check_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [6:0]  scan_codes [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  logic [23:0] ed;
  logic [5:0]  ev;
  logic [5:0]  one_sel;

  initial begin
    rst   = 1'b1;
    cs    = '1;
    sm_db = 7'h7F;
    repeat (3) @(negedge clk);
    check_eq("rst_digits", 32'(digits), 32'h0);
    check_eq("rst_valid",  32'(digit_valid), 32'h0);
    check_eq("rst_fd",     32'(frame_done), 32'h0);
    check_eq("rst_se",     32'(seg_err), 32'h0);
    check_eq("rst_be",     32'(bus_err), 32'h0);
    rst = 1'b0;

    ed = '0;
    ev = '0;
    for (int k = 0; k < 6; k++) begin
      ed[4*k +: 4] = 4'(k);
      ev[k]        = 1'b1;
      one_sel      = 6'b000001 << k;
      drive($sformatf("scan%0d", k), ~one_sel, scan_codes[k], 8, ed, ev, (k == 5) ? 1 : 0, 0, 0);
    end
    drive("idle_a", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    drive("glitch_short", 6'b111110, 7'h78, S - 1, ed, ev, 0, 0, 0);
    drive("idle_b", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    cs    = 6'b111110;
    sm_db = 7'h78;
    repeat (S) @(negedge clk);
    check_eq("lat_pre_edge", 32'(digits[3:0]), 32'h0);
    @(negedge clk);
    check_eq("lat_at_edge", 32'(digits[3:0]), 32'h7);
    ed[3:0] = 4'h7;
    drive("glitch_hold", 6'b111110, 7'h78, 3, ed, ev, 0, 0, 0);
    drive("idle_c", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    ed = 24'hFFFFFF;
    ev = 6'h3F;
    drive("static", 6'b000000, 7'h0E, 10, ed, ev, 1, 0, 0);
    drive("idle_d", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    drive("seg_err", 6'b111101, 7'h7E, 8, ed, ev, 0, 1, 0);
    drive("idle_e", '1, 7'h7F, 3, ed, ev, 0, 0, 0);
    drive("bus_err", 6'b110011, 7'h40, 8, ed, ev, 0, 0, 1);
    drive("idle_f", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    ed[11:8] = 4'h9;
    drive("val9", 6'b111011, 7'h10, 8, ed, ev, 0, 0, 0);
    ed[11:8] = 4'h0;
    ev[2]    = 1'b0;
    drive("blank", 6'b111011, 7'h7F, 8, ed, ev, 0, 0, 0);
    drive("idle_g", '1, 7'h7F, 3, ed, ev, 0, 0, 0);

    cs    = 6'b111110;
    sm_db = 7'h79;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_digits", 32'(digits), 32'h0);
    check_eq("midrst_valid",  32'(digit_valid), 32'h0);
    check_eq("midrst_pulses", 32'({frame_done, seg_err, bus_err}), 32'h0);
    rst = 1'b0;
    repeat (S) @(negedge clk);
    check_eq("rel_pre_edge", 32'(digits), 32'h0);
    @(negedge clk);
    check_eq("rel_at_edge_d", 32'(digits), 32'h000001);
    check_eq("rel_at_edge_v", 32'(digit_valid), 32'h01);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
